// File: rtl/idata_pair_fifo.sv
// Pair FIFO: buffers {do2,do1} words between the topdata source and a stalling consumer,
// tagging frame ends on the output side and summing accepted bytes mod 256.
module idata_pair_fifo #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned FRAME_LEN = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             do1,
   input  logic [7:0]             do2,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [15:0]            out_data,
   output logic                   out_last,
   output logic [$clog2(DEPTH):0] level,
   output logic [7:0]             csum
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [FW-1:0] LAST_CNT   = FW'(FRAME_LEN - 1);

   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]    csum_q, csum_d;
   logic          push, pop;

   // Handshake flags come only from registered level, so there is no in->out comb path.
   assign in_ready  = (level_q != FULL_LEVEL);
   assign out_valid = (level_q != '0);
   assign out_last  = out_valid && (frame_cnt_q == LAST_CNT);
   assign out_data  = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign csum      = csum_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      frame_cnt_d = frame_cnt_q;
      csum_d      = csum_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         csum_d   = csum_q + do1 + do2;
      end

      if (pop) begin
         rd_ptr_d    = rd_ptr_q + AW'(1);
         frame_cnt_d = out_last ? '0 : frame_cnt_q + FW'(1);
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         frame_cnt_q <= '0;
         csum_q      <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         frame_cnt_q <= frame_cnt_d;
         csum_q      <= csum_d;
      end
   end

   // NOTE: the storage array has no reset; out_valid masks stale contents, and leaving it unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {do2, do1};
      end
   end

endmodule
